lime_io_bridge: RTL and testbench

- Buffered I/O bridge between the Lime processor's I/O word ports and an external valid/ready device.
- Downstream: captures processor output writes into a FIFO and drains them over a valid/ready handshake.
- Upstream: takes one external input word per handshake into a holding register, which feeds the processor's input word.
- Decouples processor execution from slow external consumers and producers.

---
 rtl/lime_io_bridge_if.sv | 38 +++
 rtl/lime_io_bridge.sv | 115 +++++++++++
 tb/tb_lime_io_bridge.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/lime_io_bridge_if.sv
// rtl/lime_io_bridge_if.sv - processor/external handshake bundle for the Lime I/O bridge
interface lime_io_bridge_if #(
    parameter int WIDTH = 16,
    parameter int CW    = 3
) ();
    logic [WIDTH-1:0] proc_out_data;
    logic             proc_out_wr;
    logic [WIDTH-1:0] proc_in_data;
    logic             proc_in_rd;
    logic             proc_in_avail;
    logic [WIDTH-1:0] ext_out_data;
    logic             ext_out_valid;
    logic             ext_out_ready;
    logic [WIDTH-1:0] ext_in_data;
    logic             ext_in_valid;
    logic             ext_in_ready;
    logic [CW-1:0]    out_count;
    logic             out_full;
    logic             overflow;

    // Environment side: processor plus external device.
    modport master (
        output proc_out_data, proc_out_wr, proc_in_rd,
        output ext_out_ready, ext_in_data, ext_in_valid,
        input  proc_in_data, proc_in_avail,
        input  ext_out_data, ext_out_valid, ext_in_ready,
        input  out_count, out_full, overflow
    );

    // Bridge side.
    modport slave (
        input  proc_out_data, proc_out_wr, proc_in_rd,
        input  ext_out_ready, ext_in_data, ext_in_valid,
        output proc_in_data, proc_in_avail,
        output ext_out_data, ext_out_valid, ext_in_ready,
        output out_count, out_full, overflow
    );
endinterface

// File: rtl/lime_io_bridge.sv
// rtl/lime_io_bridge.sv - output FIFO and input holding register between Lime I/O ports and a valid/ready device
module lime_io_bridge #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic            CLK,
    input  logic            reset,
    lime_io_bridge_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [0:0] {
        IN_EMPTY = 1'b0,
        IN_HELD  = 1'b1
    } in_state_t;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             overflow_q;
    logic             full;
    logic             valid;
    logic             push;
    logic             pop;

    in_state_t        state_q;
    in_state_t        state_d;
    logic             capture;
    logic [WIDTH-1:0] in_data_q;

    // A full FIFO that is popping in the same cycle still has room for the write.
    assign full  = (count == CW'(DEPTH));
    assign valid = (count != '0);
    assign pop   = valid && bus.ext_out_ready;
    assign push  = bus.proc_out_wr && (!full || pop);

    // FIFO storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= bus.proc_out_data;
        end
    end

    // Pointers, occupancy and the sticky dropped-write flag.
    always_ff @(posedge CLK) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (bus.proc_out_wr && full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Head word falls through straight from storage.
    assign bus.ext_out_data  = mem[rd_ptr];
    assign bus.ext_out_valid = valid;
    assign bus.out_count     = count;
    assign bus.out_full      = full;
    assign bus.overflow      = overflow_q;

    // Input FSM state register and held word.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q   <= IN_EMPTY;
            in_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                in_data_q <= bus.ext_in_data;
            end
        end
    end

    // Input FSM next state: capture when empty, release on processor read.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IN_EMPTY: begin
                if (bus.ext_in_valid) begin
                    state_d = IN_HELD;
                    capture = 1'b1;
                end
            end
            IN_HELD: begin
                if (bus.proc_in_rd) begin
                    state_d = IN_EMPTY;
                end
            end
            default: state_d = IN_EMPTY;
        endcase
    end

    // Ready is decoded from registered state only, so proc_in_rd never reaches it combinationally.
    assign bus.ext_in_ready  = (state_q == IN_EMPTY);
    assign bus.proc_in_avail = (state_q == IN_HELD);
    assign bus.proc_in_data  = in_data_q;
endmodule

// File: tb/tb_lime_io_bridge.sv
// tb/tb_lime_io_bridge.sv - self-checking bench for lime_io_bridge
module tb_lime_io_bridge;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic CLK;
    logic reset;
    int   checks;
    int   errors;

    lime_io_bridge_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

    lime_io_bridge #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: a word queue plus the held input word.
    logic [WIDTH-1:0] mq[$];
    logic             m_ovf;
    logic             m_held;
    logic [WIDTH-1:0] m_idata;

    typedef struct {
        logic             wr;
        logic [WIDTH-1:0] wd;
        logic             rdy;
        logic             iv;
        logic [WIDTH-1:0] id;
        logic             rd;
        int               e_count;
        logic [WIDTH-1:0] e_data;
        logic             e_ovf;
        logic             e_avail;
        logic [WIDTH-1:0] e_idata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic wr, input logic [WIDTH-1:0] wd, input logic rdy,
                                input logic iv, input logic [WIDTH-1:0] id, input logic rd,
                                input int e_count, input logic [WIDTH-1:0] e_data, input logic e_ovf,
                                input logic e_avail, input logic [WIDTH-1:0] e_idata);
        vec_t v;
        v.wr = wr; v.wd = wd; v.rdy = rdy; v.iv = iv; v.id = id; v.rd = rd;
        v.e_count = e_count; v.e_data = e_data; v.e_ovf = e_ovf;
        v.e_avail = e_avail; v.e_idata = e_idata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic [WIDTH-1:0] wd, input logic rdy,
                         input logic iv, input logic [WIDTH-1:0] id, input logic rd);
        bus.proc_out_wr   = wr;
        bus.proc_out_data = wd;
        bus.ext_out_ready = rdy;
        bus.ext_in_valid  = iv;
        bus.ext_in_data   = id;
        bus.proc_in_rd    = rd;
    endtask

    // Apply one cycle of inputs, advance the model by the same rules, then sample after the edge.
    task automatic step(input logic wr, input logic [WIDTH-1:0] wd, input logic rdy,
                        input logic iv, input logic [WIDTH-1:0] id, input logic rd);
        bit do_pop;
        drive(wr, wd, rdy, iv, id, rd);
        do_pop = (mq.size() != 0) && rdy;
        if (wr && mq.size() == DEPTH && !do_pop) m_ovf = 1'b1;
        if (do_pop) void'(mq.pop_front());
        if (wr && mq.size() < DEPTH) mq.push_back(wd);
        if (!m_held && iv) begin
            m_held  = 1'b1;
            m_idata = id;
        end else if (m_held && rd) begin
            m_held = 1'b0;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input int n);
        drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        reset = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
        reset = 1'b0;
        mq.delete();
        m_ovf   = 1'b0;
        m_held  = 1'b0;
        m_idata = '0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".count"}, 32'(bus.out_count), 32'(mq.size()));
        chk({tag, ".valid"}, 32'(bus.ext_out_valid), 32'(mq.size() != 0));
        chk({tag, ".full"}, 32'(bus.out_full), 32'(mq.size() == DEPTH));
        if (mq.size() != 0) chk({tag, ".data"}, 32'(bus.ext_out_data), 32'(mq[0]));
        chk({tag, ".ovf"}, 32'(bus.overflow), 32'(m_ovf));
        chk({tag, ".avail"}, 32'(bus.proc_in_avail), 32'(m_held));
        chk({tag, ".in_ready"}, 32'(bus.ext_in_ready), 32'(!m_held));
        chk({tag, ".in_data"}, 32'(bus.proc_in_data), 32'(m_idata));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".count"}, 32'(bus.out_count), 32'd0);
        chk({tag, ".valid"}, 32'(bus.ext_out_valid), 32'd0);
        chk({tag, ".full"}, 32'(bus.out_full), 32'd0);
        chk({tag, ".ovf"}, 32'(bus.overflow), 32'd0);
        chk({tag, ".avail"}, 32'(bus.proc_in_avail), 32'd0);
        chk({tag, ".in_data"}, 32'(bus.proc_in_data), 32'd0);
        chk({tag, ".in_ready"}, 32'(bus.ext_in_ready), 32'd1);
    endtask

    initial begin
        logic [WIDTH-1:0] prev_data;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);

        // Single write, hold under backpressure, drain.
        vecs.push_back(mk(1, 16'h1234, 0, 0, 0, 0, 1, 16'h1234, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 16'h1234, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        // Fill, drop one, drain in order.
        vecs.push_back(mk(1, 16'hA000, 0, 0, 0, 0, 1, 16'hA000, 0, 0, 0));
        vecs.push_back(mk(1, 16'hA001, 0, 0, 0, 0, 2, 16'hA000, 0, 0, 0));
        vecs.push_back(mk(1, 16'hA002, 0, 0, 0, 0, 3, 16'hA000, 0, 0, 0));
        vecs.push_back(mk(1, 16'hA003, 0, 0, 0, 0, 4, 16'hA000, 0, 0, 0));
        vecs.push_back(mk(1, 16'hBEEF, 0, 0, 0, 0, 4, 16'hA000, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 3, 16'hA001, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 2, 16'hA002, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 16'hA003, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        // Input holding register.
        vecs.push_back(mk(0, 0, 0, 1, 16'h00C3, 0, 0, 0, 1, 1, 16'h00C3));
        vecs.push_back(mk(0, 0, 0, 1, 16'h7777, 0, 0, 0, 1, 1, 16'h00C3));
        vecs.push_back(mk(0, 0, 0, 0, 16'h7777, 1, 0, 0, 1, 0, 16'h00C3));
        vecs.push_back(mk(0, 0, 0, 1, 16'h7777, 0, 0, 0, 1, 1, 16'h7777));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 16'h7777));

        do_reset(2);
        check_reset_state("reset");

        foreach (vecs[i]) begin
            step(vecs[i].wr, vecs[i].wd, vecs[i].rdy, vecs[i].iv, vecs[i].id, vecs[i].rd);
            chk($sformatf("vec%0d.count", i), 32'(bus.out_count), 32'(vecs[i].e_count));
            chk($sformatf("vec%0d.valid", i), 32'(bus.ext_out_valid), 32'(vecs[i].e_count != 0));
            chk($sformatf("vec%0d.full", i), 32'(bus.out_full), 32'(vecs[i].e_count == DEPTH));
            if (vecs[i].e_count != 0)
                chk($sformatf("vec%0d.data", i), 32'(bus.ext_out_data), 32'(vecs[i].e_data));
            chk($sformatf("vec%0d.ovf", i), 32'(bus.overflow), 32'(vecs[i].e_ovf));
            chk($sformatf("vec%0d.avail", i), 32'(bus.proc_in_avail), 32'(vecs[i].e_avail));
            chk($sformatf("vec%0d.in_ready", i), 32'(bus.ext_in_ready), 32'(!vecs[i].e_avail));
            chk($sformatf("vec%0d.in_data", i), 32'(bus.proc_in_data), 32'(vecs[i].e_idata));
        end

        // Full FIFO with simultaneous push and pop.
        do_reset(1);
        for (int i = 0; i < 4; i++) step(1, 16'hC000 + 16'(i), 0, 0, 0, 0);
        check_model("fill");
        step(1, 16'h5555, 1, 0, 0, 0);
        chk("pushpop.count", 32'(bus.out_count), 32'd4);
        chk("pushpop.ovf", 32'(bus.overflow), 32'd0);
        check_model("pushpop");
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 0, 0, 0);
            check_model("pushpop_drain");
        end

        // Streaming: write and ready every cycle.
        for (int i = 0; i < 12; i++) begin
            prev_data = bus.ext_out_data;
            step(1, 16'h3000 + 16'(i), 1, 0, 0, 0);
            chk("stream.count", 32'(bus.out_count), 32'd1);
            check_model("stream");
        end
        step(0, 0, 1, 0, 0, 0);
        check_model("stream_end");

        // Reset with buffered words and a held input.
        for (int i = 0; i < 3; i++) step(1, 16'hD000 + 16'(i), 0, (i == 0), 16'h0042, 0);
        for (int i = 0; i < 3; i++) step(1, 16'hD100, 0, 0, 0, 0);
        check_model("pre_reset");
        do_reset(1);
        check_reset_state("midreset");

        // Randomized traffic with both paths active; one reset partway through.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                do_reset(1);
                check_reset_state("rand_reset");
            end
            step($urandom_range(0, 3) != 0, 16'($urandom), (i % 64 < 24) ? 1'b0 : 1'($urandom),
                 1'($urandom), 16'($urandom), 1'($urandom));
            check_model("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
